pf_checker: RTL and testbench
=============================

Name: pf_checker

Overview:
- Receiver-side check for the ALU parity flag. It accepts a stream of (Dato, PF) beats, where PF was produced by the even-parity flag generator (PF = 1 when Dato holds an even number of ones).
- It recomputes the parity, flags mismatches and forwards each beat through a one-entry registered stage with valid/ready handshake.
- It keeps error statistics and locks the input after a run of consecutive errors until software clears it.
- It sits between the ALU flag bus and the result/status register block.

Parameters:
- DATA_W, 6, width of Dato.
- CNT_W, 8, width of the saturating total-error counter.
- LOCK_THR, 4, number of consecutive errored beats that forces LOCK; 0 disables locking.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- Dato  input  DATA_W  data word.
- PF  input  1  received parity flag.
- clr  input  1  synchronous clear of statistics and LOCK.
- out_valid  output  1  registered beat valid.
- out_ready  input  1  downstream accepts the beat.
- Dato_out  output  DATA_W  registered copy of Dato.
- PF_err  output  1  1 = PF mismatched for this beat.
- err_sticky  output  1  set on any errored accept, held until clr.
- err_cnt  output  CNT_W  total errored accepts, saturating.
- locked  output  1  1 while FSM is in LOCK.

Behaviour:
- Clocking and reset: one clock (CLK). Reset is asynchronous and active-low (RST_N).
- Reset values: out_valid=0, Dato_out=0, PF_err=0, err_sticky=0, err_cnt=0, locked=0, consecutive counter=0, FSM=RUN. in_ready reads 1 from the first cycle after reset release.
- Parity rule: expected = ~^Dato. err = PF ^ expected.
- Accept: occurs when in_valid & in_ready.
- in_ready = (state==RUN) & (~out_valid | out_ready). It is combinational, so a full stage that is being drained in the same cycle still accepts (full throughput, 1 beat/cycle).
- Latency: 1 cycle. A beat accepted at edge N is on Dato_out/PF_err with out_valid=1 after edge N.
- Output stage:
  - On accept: load Dato_out, PF_err, and set out_valid=1.
  - Else if out_ready: out_valid=0.
  - Dato_out and PF_err hold while out_valid & ~out_ready.
- Consecutive counter (width clog2(LOCK_THR+1)):
  - Errored accept: +1.
  - Clean accept: reset to 0.
  - No accept: hold.
- err_cnt: +1 per errored accept. Saturates at 2^CNT_W-1 with no wrap.
- err_sticky: set by any errored accept.
- FSM states:
  - RUN -> LOCK when an errored accept brings the consecutive counter to LOCK_THR (LOCK_THR≠0).
  - LOCK -> RUN only on clr.
  - In LOCK, in_ready=0 and locked=1. A beat already in the output stage still drains normally.
- clr (one cycle, synchronous):
  - Zeroes err_cnt, err_sticky and the consecutive counter; FSM -> RUN.
  - Does not touch the output stage.
  - clr coincident with an errored accept: the beat is still forwarded with PF_err=1, but clr wins on all statistics (they end at 0).
- Reset mid-transfer: a pending beat is discarded (out_valid=0). No handshake is assumed to complete.

Optional Feature:
- Macro: PF_CHK_ODD_EN.
- Defined: the checker also supports odd-parity producers via input port odd_sel (1 bit). With odd_sel=1, expected = ^Dato; with odd_sel=0, even rule as above.
- Undefined: the port is absent and only even parity is checked.

Decomposition:
- Shared package pf_pkg holds:
  - DATA_W default.
  - FSM state enum pf_chk_state_t {RUN, LOCK}.
  - Function pf_expected(data, odd) returning the expected flag.
- One natural sub-module: pf_chk_stage, the one-entry valid/ready register carrying {Dato, PF_err}. The top holds the FSM and counters.

Test Plan:
- Clean beat: Dato=6'b000011, PF=1, out_ready=1 -> next cycle out_valid=1, Dato_out=6'b000011, PF_err=0, err_cnt=0.
- Error beat: Dato=6'b000111, PF=1 -> PF_err=1, err_sticky=1, err_cnt=1.
- Backpressure: out_ready=0 with a beat held, new beat presented -> in_ready=0, Dato_out unchanged. Then out_ready=1 -> new beat accepted in the same cycle, no beat lost or duplicated.
- Lock: 4 consecutive errored beats (Dato=6'b000001, PF=1) -> locked=1 and in_ready=0 after the 4th. clr pulse -> locked=0, err_cnt=0, err_sticky=0, in_ready=1. Also: 3 errors, 1 clean, 3 errors -> no lock.
- Saturation: CNT_W=2, 5 errored beats with LOCK_THR=0 -> err_cnt stays 3.
- Reset: assert RST_N=0 asynchronously while out_valid=1 -> out_valid, err_cnt, locked all 0 immediately.

Source files
------------

// File: rtl/pf_pkg.sv
// Shared types and helpers for the parity-flag checker.
package pf_pkg;

  localparam int PF_DATA_W = 6;

  typedef enum logic {
    RUN  = 1'b0,
    LOCK = 1'b1
  } pf_chk_state_t;

  // Callers zero-extend their data word; leading zeros do not change parity.
  function automatic logic pf_expected(input logic [63:0] data, input logic odd);
    return odd ? (^data) : (~^data);
  endfunction

endpackage

// File: rtl/pf_checker_if.sv
// Beat bus for the parity checker: input handshake plus registered output handshake.
interface pf_checker_if #(
  parameter int DATA_W = 6
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] Dato;
  logic              PF;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] Dato_out;
  logic              PF_err;

  modport slave (
    input  in_valid,
    input  Dato,
    input  PF,
    input  out_ready,
    output in_ready,
    output out_valid,
    output Dato_out,
    output PF_err
  );

  modport master (
    output in_valid,
    output Dato,
    output PF,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  Dato_out,
    input  PF_err
  );

endinterface

// File: rtl/pf_chk_stage.sv
// One-entry registered valid/ready stage carrying {Dato, PF_err}; 1-cycle latency.
// Holds its contents while out_valid & ~out_ready; the caller gates loads with in_ready.
module pf_chk_stage
  import pf_pkg::*;
#(
  parameter int DATA_W = PF_DATA_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              err_in,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] Dato_out,
  output logic              PF_err
);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_valid <= 1'b0;
      Dato_out  <= '0;
      PF_err    <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      Dato_out  <= din;
      PF_err    <= err_in;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pf_checker.sv
// Receiver-side ALU parity-flag checker: flags mismatches, counts errors, locks after a run of errors.
// Optional macro PF_CHK_ODD_EN adds odd_sel to check odd-parity producers as well.
module pf_checker
  import pf_pkg::*;
#(
  parameter int DATA_W   = PF_DATA_W,
  parameter int CNT_W    = 8,
  parameter int LOCK_THR = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
`ifdef PF_CHK_ODD_EN
  input  logic              odd_sel,
`endif
  pf_checker_if.slave       bus,
  input  logic              clr,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              locked
);

  // A zero threshold still needs a legal counter width; the counter is then unused.
  localparam int CONS_W = (LOCK_THR > 0) ? $clog2(LOCK_THR + 1) : 1;
  localparam logic [CONS_W:0] THR = (CONS_W + 1)'(LOCK_THR);

  pf_chk_state_t     state;
  logic [CONS_W-1:0] cons;
  logic [CONS_W:0]   cons_inc;
  logic              odd;
  logic              err;
  logic              accept;
  logic              lock_hit;

`ifdef PF_CHK_ODD_EN
  assign odd = odd_sel;
`else
  assign odd = 1'b0;
`endif

  assign err          = bus.PF ^ pf_expected(64'(bus.Dato), odd);
  assign bus.in_ready = (state == RUN) & (~bus.out_valid | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  assign cons_inc     = {1'b0, cons} + {{CONS_W{1'b0}}, 1'b1};
  assign lock_hit     = accept & err & (LOCK_THR != 0) & (cons_inc == THR);

  pf_chk_stage #(
    .DATA_W (DATA_W)
  ) u_stage (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .load      (accept),
    .din       (bus.Dato),
    .err_in    (err),
    .out_ready (bus.out_ready),
    .out_valid (bus.out_valid),
    .Dato_out  (bus.Dato_out),
    .PF_err    (bus.PF_err)
  );

  // clr has priority over every statistic, even when an errored beat lands in the same cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= RUN;
      locked     <= 1'b0;
      cons       <= '0;
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else if (clr) begin
      state      <= RUN;
      locked     <= 1'b0;
      cons       <= '0;
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (accept) begin
        if (err) begin
          err_sticky <= 1'b1;
          if (err_cnt != {CNT_W{1'b1}}) begin
            err_cnt <= err_cnt + CNT_W'(1);
          end
          if (cons != {CONS_W{1'b1}}) begin
            cons <= cons_inc[CONS_W-1:0];
          end
        end else begin
          cons <= '0;
        end
      end
      case (state)
        RUN: begin
          if (lock_hit) begin
            state  <= LOCK;
            locked <= 1'b1;
          end
        end
        LOCK: begin
          state  <= LOCK;
          locked <= 1'b1;
        end
        default: begin
          state  <= RUN;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pf_checker.sv
// Scoreboard bench for pf_checker: directed beats, expected beats queued, monitor compares.
module tb_pf_checker;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       s_clr;
  logic       odd_sel;
  logic       err_sticky;
  logic [7:0] err_cnt;
  logic       locked;
  logic       s_sticky;
  logic [1:0] s_err_cnt;
  logic       s_locked;

  int n_vec;
  int n_bad;

  typedef struct {
    logic [5:0] d;
    logic       e;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  pf_checker_if #(.DATA_W(6)) bus  ();
  pf_checker_if #(.DATA_W(6)) sbus ();

  pf_checker #(.DATA_W(6), .CNT_W(8), .LOCK_THR(4)) u_dut (
    .CLK        (clk),
`ifdef PF_CHK_ODD_EN
    .odd_sel    (odd_sel),
`endif
    .RST_N      (rst_n),
    .bus        (bus.slave),
    .clr        (clr),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt),
    .locked     (locked)
  );

  pf_checker #(.DATA_W(6), .CNT_W(2), .LOCK_THR(0)) u_sat (
    .CLK        (clk),
`ifdef PF_CHK_ODD_EN
    .odd_sel    (odd_sel),
`endif
    .RST_N      (rst_n),
    .bus        (sbus.slave),
    .clr        (s_clr),
    .err_sticky (s_sticky),
    .err_cnt    (s_err_cnt),
    .locked     (s_locked)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Present one beat on the main DUT; returns 1 ns after the edge that accepts it.
  task automatic send(input logic [5:0] d, input logic pf, input logic exp_err);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.Dato     = d;
    bus.PF       = pf;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_timeout: in_ready stayed 0 for Dato=%b, expected 1", d);
      bus.in_valid = 1'b0;
    end else begin
      q.push_back('{d: d, e: exp_err});
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      n_vec++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL beat_extra: got Dato_out=%b PF_err=%b, expected no beat",
                 bus.Dato_out, bus.PF_err);
      end else begin
        mon_e = q.pop_front();
        if ({bus.Dato_out, bus.PF_err} !== {mon_e.d, mon_e.e}) begin
          n_bad++;
          $display("FAIL beat_data: got Dato_out=%b PF_err=%b, expected Dato_out=%b PF_err=%b",
                   bus.Dato_out, bus.PF_err, mon_e.d, mon_e.e);
        end
      end
    end
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    clr = 1'b0;
    s_clr = 1'b0;
    odd_sel = 1'b0;
    bus.in_valid = 1'b0;
    bus.Dato = '0;
    bus.PF = 1'b0;
    bus.out_ready = 1'b1;
    sbus.in_valid = 1'b0;
    sbus.Dato = '0;
    sbus.PF = 1'b0;
    sbus.out_ready = 1'b1;

    #3;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_Dato_out", 32'(bus.Dato_out), 0);
    chk("rst_PF_err", 32'(bus.PF_err), 0);
    chk("rst_err_sticky", 32'(err_sticky), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_locked", 32'(locked), 0);
    #9;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 1);

    // Saturating counter on the CNT_W=2, LOCK_THR=0 instance: 5 errors stop at 3.
    sbus.in_valid = 1'b1;
    sbus.Dato = 6'b000001;
    sbus.PF = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    sbus.in_valid = 1'b0;
    chk("sat_err_cnt", 32'(s_err_cnt), 3);
    chk("sat_locked", 32'(s_locked), 0);
    chk("sat_in_ready", 32'(sbus.in_ready), 1);
    chk("sat_PF_err", 32'(sbus.PF_err), 1);

    // Clean beat, then errored beat, then odd-weight word with correct PF=0.
    send(6'b000011, 1'b1, 1'b0);
    chk("clean_out_valid", 32'(bus.out_valid), 1);
    chk("clean_err_cnt", 32'(err_cnt), 0);
    chk("clean_sticky", 32'(err_sticky), 0);
    send(6'b000111, 1'b1, 1'b1);
    chk("err_cnt_1", 32'(err_cnt), 1);
    chk("err_sticky_1", 32'(err_sticky), 1);
    send(6'b000111, 1'b0, 1'b0);
    chk("err_cnt_hold", 32'(err_cnt), 1);

    // Backpressure: A held, B presented and blocked, then both move in one edge.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(6'b101010, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.Dato = 6'b111111;
    bus.PF = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_in_ready", 32'(bus.in_ready), 0);
    chk("bp_Dato_hold", 32'(bus.Dato_out), 32'(6'b101010));
    @(posedge clk);
    #1;
    q.push_back('{d: 6'b111111, e: 1'b0});
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("bp_B_loaded", 32'(bus.Dato_out), 32'(6'b111111));
    @(posedge clk);
    #1;
    chk("bp_drained", 32'(bus.out_valid), 0);

    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("clr_err_cnt", 32'(err_cnt), 0);
    chk("clr_sticky", 32'(err_sticky), 0);

    // 3 errors, 1 clean, 3 errors: no lock. A fourth consecutive error locks.
    repeat (3) send(6'b000001, 1'b1, 1'b1);
    send(6'b000011, 1'b1, 1'b0);
    repeat (3) send(6'b000001, 1'b1, 1'b1);
    chk("nolock_locked", 32'(locked), 0);
    chk("nolock_err_cnt", 32'(err_cnt), 6);
    send(6'b000001, 1'b1, 1'b1);
    chk("lock_locked", 32'(locked), 1);
    chk("lock_in_ready", 32'(bus.in_ready), 0);
    chk("lock_err_cnt", 32'(err_cnt), 7);
    bus.in_valid = 1'b1;
    bus.Dato = 6'b110000;
    bus.PF = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("locked_blocks", 32'(bus.in_ready), 0);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("unlock_locked", 32'(locked), 0);
    chk("unlock_err_cnt", 32'(err_cnt), 0);
    chk("unlock_sticky", 32'(err_sticky), 0);
    chk("unlock_in_ready", 32'(bus.in_ready), 1);

    // clr alongside an errored accept: beat forwarded with PF_err=1, stats end at 0.
    clr = 1'b1;
    send(6'b000001, 1'b1, 1'b1);
    clr = 1'b0;
    chk("clr_coinc_err_cnt", 32'(err_cnt), 0);
    chk("clr_coinc_sticky", 32'(err_sticky), 0);

    // Lock with the fourth beat held in the stage, then reset asynchronously.
    repeat (3) send(6'b000001, 1'b1, 1'b1);
    send(6'b010101, 1'b1, 1'b1);
    bus.out_ready = 1'b0;
    chk("pre_rst_locked", 32'(locked), 1);
    chk("pre_rst_out_valid", 32'(bus.out_valid), 1);
    chk("pre_rst_err_cnt", 32'(err_cnt), 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(bus.out_valid), 0);
    chk("async_rst_err_cnt", 32'(err_cnt), 0);
    chk("async_rst_locked", 32'(locked), 0);
    chk("async_rst_sticky", 32'(err_sticky), 0);
    q.delete();
    bus.out_ready = 1'b1;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rerun_in_ready", 32'(bus.in_ready), 1);
    send(6'b110011, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 32'(q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
